// File: rtl/core_sequencer.sv
// Multi-cycle fetch / execute / writeback sequencer for a single-issue core.
// Provides run/step control, a bounded fetch wait and a sticky fault state.
module core_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        reg_we,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_HALTED,
    S_FETCH,
    S_EXECUTE,
    S_WRITEBACK,
    S_FAULT
  } state_t;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] EBREAK     = 32'h0010_0073;

  localparam int unsigned      WAIT_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              step_flag;
  logic              run_q;
  logic              br_taken_q;
  logic [31:0]       br_target_q;

  logic is_alu, is_branch, is_ebreak, is_legal, misaligned, halt_after_wb;

  // Decode always looks at the latched word, so it is stable through EXECUTE and WRITEBACK.
  assign is_alu        = (instr[6:0] == OPC_OP_IMM) || (instr[6:0] == OPC_OP);
  assign is_branch     = (instr[6:0] == OPC_BRANCH);
  assign is_ebreak     = (instr == EBREAK);
  assign is_legal      = is_alu || is_branch || is_ebreak;
  assign misaligned    = is_branch && branch_taken && (branch_target[1:0] != 2'b00);
  assign halt_after_wb = is_ebreak || step_flag || !run;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALTED: begin
        if (step || (run && !run_q)) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack)                   state_d = S_EXECUTE;
        else if (wait_cnt == WAIT_LAST) state_d = S_FAULT;
      end
      S_EXECUTE: begin
        if (!is_legal || misaligned) state_d = S_FAULT;
        else                         state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        state_d = halt_after_wb ? S_HALTED : S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HALTED;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      retired     <= 32'h0;
      wait_cnt    <= '0;
      step_flag   <= 1'b0;
      run_q       <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= 32'h0;
    end else begin
      state_q <= state_d;
      run_q   <= run;

      // Counts consecutive unacknowledged fetch cycles; zero whenever FETCH is entered.
      if (state_q == S_FETCH && !imem_ack) wait_cnt <= wait_cnt + 1'b1;
      else                                 wait_cnt <= '0;

      if (state_q == S_FETCH && imem_ack) instr <= imem_rdata;

      if (state_q == S_HALTED && step)  step_flag <= 1'b1;
      else if (state_q == S_WRITEBACK)  step_flag <= 1'b0;

      if (state_q == S_EXECUTE) begin
        br_taken_q  <= branch_taken;
        br_target_q <= branch_target;
      end

      if (state_q == S_WRITEBACK) begin
        pc      <= (is_branch && br_taken_q) ? br_target_q : pc + 32'd4;
        retired <= retired + 32'd1;
      end
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc;
  assign reg_we    = (state_q == S_WRITEBACK) && is_alu;
  assign halted    = (state_q == S_HALTED);
  assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: an instruction-level model predicts every
// cycle's outputs, checked on the falling edge, plus literal spot checks.
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int          FETCH_TIMEOUT = 15;

  localparam logic [31:0] W_ADDI = 32'h00C0_0293;
  localparam logic [31:0] W_ADD  = 32'h0031_00B3;
  localparam logic [31:0] W_BEQ  = 32'h0000_0063;
  localparam logic [31:0] W_EBRK = 32'h0010_0073;
  localparam logic [31:0] W_BAD  = 32'h0000_007F;

  logic clk    = 1'b0;
  bit   clk_en = 1'b1;

  logic        reset, run, step, imem_ack, branch_taken;
  logic [31:0] imem_rdata, branch_target;
  logic        imem_req, reg_we, halted, fault;
  logic [31:0] imem_addr, instr, pc, retired;

  int n_vec  = 0;
  int n_fail = 0;

  bit          exp_valid = 1'b0;
  logic        exp_req, exp_we, exp_halted, exp_fault;
  logic [31:0] exp_pc, exp_retired, exp_instr;

  logic [31:0] m_pc, m_retired, m_instr;
  bit          m_fault, m_stepping;

  core_sequencer #(
    .RESET_PC     (RESET_PC),
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .step         (step),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .reg_we       (reg_we),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .halted       (halted),
    .fault        (fault),
    .retired      (retired)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("imem_req",  imem_req,  exp_req);
      check("imem_addr", imem_addr, exp_pc);
      check("reg_we",    reg_we,    exp_we);
      check("halted",    halted,    exp_halted);
      check("fault",     fault,     exp_fault);
      check("pc",        pc,        exp_pc);
      check("retired",   retired,   exp_retired);
      check("instr",     instr,     exp_instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input bit req, input bit we, input bit hlt, input bit flt);
    exp_req     = req;
    exp_we      = we;
    exp_halted  = hlt;
    exp_fault   = flt;
    exp_pc      = m_pc;
    exp_retired = m_retired;
    exp_instr   = m_instr;
  endtask

  task automatic reset_model();
    m_pc       = RESET_PC;
    m_retired  = 32'h0;
    m_instr    = 32'h0;
    m_fault    = 1'b0;
    m_stepping = 1'b0;
  endtask

  task automatic do_reset();
    run = 1'b0; step = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
    reset = 1'b0;
    reset_model();
    expect_cycle(0, 0, 1, 0);
    exp_valid = 1'b1;
    tick();
    reset = 1'b1;
    expect_cycle(0, 0, 1, 0);
  endtask

  // Called in a HALTED cycle; the sequencer is in FETCH on return.
  task automatic start(input bit use_step);
    if (use_step) begin
      step = 1'b1;
      m_stepping = 1'b1;
    end else begin
      run = 1'b1;
    end
    tick();
    step = 1'b0;
  endtask

  // Called in the first FETCH cycle of an instruction; returns in the cycle after it ends.
  task automatic do_instr(input logic [31:0] word, input int delay, input bit tk,
                          input logic [31:0] tgt, input bit drop_run);
    bit is_alu, is_br, is_ebrk, legal, go_halt;
    is_alu  = (word[6:0] == 7'b0010011) || (word[6:0] == 7'b0110011);
    is_br   = (word[6:0] == 7'b1100011);
    is_ebrk = (word == 32'h0010_0073);
    legal   = is_alu || is_br || is_ebrk;
    for (int i = 0; i <= delay; i++) begin
      expect_cycle(1, 0, 0, 0);
      if (drop_run && i == 0) run = 1'b0;
      imem_ack   = (i == delay);
      imem_rdata = (i == delay) ? word : 32'hDEAD_BEEF;
      tick();
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    m_instr    = word;
    expect_cycle(0, 0, 0, 0);
    branch_taken  = tk;
    branch_target = tgt;
    tick();
    branch_taken  = ~tk;
    branch_target = ~tgt;
    if (!legal || (is_br && tk && tgt[1:0] != 2'b00)) begin
      m_fault = 1'b1;
      expect_cycle(0, 0, 0, 1);
      return;
    end
    expect_cycle(0, is_alu, 0, 0);
    go_halt = is_ebrk || m_stepping || !run;
    tick();
    m_pc      = (is_br && tk) ? tgt : m_pc + 32'd4;
    m_retired = m_retired + 32'd1;
    if (go_halt) begin
      m_stepping = 1'b0;
      expect_cycle(0, 0, 1, 0);
    end else begin
      expect_cycle(1, 0, 0, 0);
    end
  endtask

  task automatic do_timeout();
    for (int i = 0; i < FETCH_TIMEOUT; i++) begin
      expect_cycle(1, 0, 0, 0);
      imem_ack = 1'b0;
      tick();
    end
    m_fault = 1'b1;
    expect_cycle(0, 0, 0, 1);
  endtask

  // Idle in HALTED or FAULT with stray acks (and, in FAULT, run/step activity).
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_fault) expect_cycle(0, 0, 0, 1);
      else         expect_cycle(0, 0, 1, 0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_0013 + i;
      if (m_fault) begin
        run  = 1'b1;
        step = i[0];
      end
      tick();
    end
    imem_ack = 1'b0;
    step     = 1'b0;
    if (m_fault) expect_cycle(0, 0, 0, 1);
    else         expect_cycle(0, 0, 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    branch_taken = 1'b0; branch_target = 32'h0;
    #1 reset = 1'b0;
    #1;
    check("rst_halted",  halted,   32'h1);
    check("rst_req",     imem_req, 32'h0);
    check("rst_we",      reg_we,   32'h0);
    check("rst_fault",   fault,    32'h0);
    check("rst_pc",      pc,       32'h0);
    check("rst_retired", retired,  32'h0);

    // Continuous run, zero-wait ADDI, then run dropped during the next fetch.
    do_reset();
    start(0);
    do_instr(W_ADDI, 0, 0, 32'h0, 0);
    check("run_pc1",      pc,       32'h4);
    check("run_retired1", retired,  32'h1);
    check("run_req1",     imem_req, 32'h1);
    do_instr(W_ADD, 0, 0, 32'h0, 1);
    check("drop_halted", halted, 32'h1);
    check("drop_pc",     pc,     32'h8);
    idle(2);

    // Single stepping, second step with a 3-cycle ack delay.
    do_reset();
    start(1);
    do_instr(W_ADDI, 0, 0, 32'h0, 0);
    check("step1_halted", halted, 32'h1);
    check("step1_pc",     pc,     32'h4);
    idle(2);
    start(1);
    do_instr(W_ADDI, 3, 0, 32'h0, 0);
    check("step2_pc",      pc,      32'h8);
    check("step2_retired", retired, 32'h2);

    // Branches: taken, not-taken with odd target, pc wrap, misaligned fault.
    do_reset();
    start(1);
    do_instr(W_BEQ, 0, 1, 32'h40, 0);
    check("br_taken_pc", pc, 32'h40);
    start(1);
    do_instr(W_BEQ, 1, 0, 32'h42, 0);
    check("br_nt_pc", pc, 32'h44);
    start(1);
    do_instr(W_BEQ, 0, 1, 32'hFFFF_FFFC, 0);
    start(1);
    do_instr(W_ADDI, 0, 0, 32'h0, 0);
    check("wrap_pc", pc, 32'h0);
    start(1);
    do_instr(W_BEQ, 0, 1, 32'h42, 0);
    check("br_mis_fault",   fault,   32'h1);
    check("br_mis_retired", retired, 32'h4);
    idle(3);

    // Illegal opcode faults without retiring.
    do_reset();
    start(1);
    do_instr(W_ADDI, 0, 0, 32'h0, 0);
    start(1);
    do_instr(W_BAD, 0, 0, 32'h0, 0);
    check("ill_fault",   fault,   32'h1);
    check("ill_retired", retired, 32'h1);
    check("ill_pc",      pc,      32'h4);
    idle(3);

    // EBREAK halts despite run staying high; stray acks in HALTED are ignored.
    do_reset();
    start(0);
    do_instr(W_EBRK, 0, 0, 32'h0, 0);
    check("ebrk_halted", halted, 32'h1);
    check("ebrk_pc",     pc,     32'h4);
    idle(3);

    // Ack on the last allowed cycle succeeds; a withheld ack faults.
    do_reset();
    start(0);
    do_instr(W_ADDI, FETCH_TIMEOUT - 1, 0, 32'h0, 0);
    do_timeout();
    check("to_fault", fault,    32'h1);
    check("to_pc",    pc,       32'h4);
    check("to_req",   imem_req, 32'h0);
    idle(2);

    // Asynchronous reset mid-fetch with the clock stopped.
    do_reset();
    start(0);
    do_instr(W_ADDI, 0, 0, 32'h0, 0);
    expect_cycle(1, 0, 0, 0);
    tick();
    exp_valid = 1'b0;
    clk_en    = 1'b0;
    #2;
    reset = 1'b0;
    run   = 1'b0;
    #1;
    check("async_halted",  halted,   32'h1);
    check("async_pc",      pc,       RESET_PC);
    check("async_req",     imem_req, 32'h0);
    check("async_retired", retired,  32'h0);
    check("async_instr",   instr,    32'h0);
    reset_model();
    expect_cycle(0, 0, 1, 0);
    #10;
    clk_en    = 1'b1;
    exp_valid = 1'b1;
    tick();
    reset = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 15: max wait cycles for imem_ack before fault.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; high = execute continuously; rising edge starts execution from HALTED.
REQ-006 step  input  1  one-cycle pulse; in HALTED, executes exactly one instruction.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  32  fetch byte address, equal to pc.
REQ-009 imem_ack  input  1  fetch data valid this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr  output  32  latched instruction presented to datapath.
REQ-012 reg_we  output  1  register-file write enable, one-cycle pulse.
REQ-013 branch_taken  input  1  datapath branch decision, sampled in EXECUTE.
REQ-014 branch_target  input  32  datapath branch target, sampled in EXECUTE.
REQ-015 pc  output  32  current program counter.
REQ-016 halted  output  1  high only in HALTED.
REQ-017 fault  output  1  high only in FAULT.
REQ-018 retired  output  32  count of retired instructions.

Function
REQ-019 FSM states SHALL be HALTED, FETCH, EXECUTE, WRITEBACK, FAULT.
REQ-020 HALTED: imem_req=0; go to FETCH on run rising edge (registered compare) or step=1; step sets a single-step flag.
REQ-021 FETCH: imem_req=1, imem_addr=pc held stable until ack; on imem_ack=1 latch imem_rdata into instr, go to EXECUTE.
REQ-022 FETCH wait counter: reset on FETCH entry, +1 per cycle without ack. Reaching FETCH_TIMEOUT -> FAULT with pc unchanged.
REQ-023 imem_ack outside FETCH SHALL be ignored.
REQ-024 EXECUTE decodes instr[6:0]. Legal: 0010011 (OP-IMM), 0110011 (OP), 1100011 (BRANCH). Also legal: instr==32'h0010_0073 (EBREAK). Anything else -> FAULT, nothing retired.
REQ-025 EXECUTE registers branch_taken and branch_target. Taken BRANCH with branch_target[1:0]!=0 -> FAULT, pc unchanged.
REQ-026 WRITEBACK: reg_we=1 for OP-IMM/OP only.
REQ-027 WRITEBACK pc update: taken BRANCH -> pc=branch_target; otherwise pc=pc+4, wrapping modulo 2^32.
REQ-028 WRITEBACK: retired increments by 1, wrapping modulo 2^32.
REQ-029 After WRITEBACK: go to HALTED if EBREAK, single-step flag set, or run=0; otherwise go to FETCH. Single-step flag clears on leaving WRITEBACK.
REQ-030 run falling during FETCH/EXECUTE SHALL NOT abort; the current instruction completes, then HALTED.
REQ-031 Throughput with zero-wait ack (ack in first FETCH cycle) SHALL be 3 cycles per instruction.
REQ-032 FAULT is sticky until reset: imem_req=0, reg_we=0; pc holds faulting instruction address.

Reset
REQ-033 reset=0 SHALL immediately, without clock, force state=HALTED, pc=RESET_PC, instr=0, retired=0, wait counter=0, and clear the step and run-edge registers.
REQ-034 During reset: imem_req=0, reg_we=0, fault=0, halted=1.
REQ-035 The first state transition SHALL occur on the first rising clk edge after reset returns high.

Verification
REQ-036 run=1, zero-wait ack, imem_rdata=32'h00C0_0293 (ADDI x5,x0,12) -> imem_addr=0, reg_we pulse on 3rd cycle, then pc=4, retired=1.
REQ-037 run=0, step pulse from HALTED -> one instruction retires, halted=1, pc=4. Second step -> pc=8, retired=2.
REQ-038 Ack delayed 3 cycles -> imem_req/imem_addr stable throughout. Ack withheld 15 cycles -> fault=1, pc unchanged, imem_req=0.
REQ-039 BRANCH with branch_taken=1, target 32'h40 -> pc=32'h40, reg_we=0. Target 32'h42 -> fault=1.
REQ-040 imem_rdata=32'h0000_007F -> fault=1, retired unchanged. imem_rdata=32'h0010_0073 -> halted=1, pc=old+4 even with run=1.
REQ-041 reset asserted mid-FETCH with clk stopped -> halted=1, pc=RESET_PC, imem_req=0, retired=0 immediately.
